// File: rtl/sudoku_grid_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// sudoku_grid_ctrl : cursor navigation and row-buffered cell editing for a
//                    row-addressed Sudoku board RAM
// Revision 1.0
// ============================================================================

module sudoku_grid_ctrl #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int WRAP  = 1,
  parameter int WMODE = 0,
  localparam int AW   = ($clog2(N) < 1) ? 1 : $clog2(N),
  localparam int RW   = N * (W + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [W-1:0]    userNum,
  input  logic            upButton,
  input  logic            downButton,
  input  logic            leftButton,
  input  logic            rightButton,
  input  logic            writeBit,
  input  logic [RW-1:0]   RamDat,
  output logic [AW-1:0]   RamAddr,
  output logic [RW-1:0]   RamWriteBuf,
  output logic            RamWriteBit,
  output logic [N*W-1:0]  currentRow,
  output logic [W-1:0]    currentNum,
  output logic [AW-1:0]   curRow,
  output logic [AW-1:0]   curCol,
  output logic            noWrite,
  output logic            badNum,
  output logic            busy
);

  localparam logic [AW-1:0] c_LAST = AW'(N - 1);
  localparam logic [W-1:0]  c_NMAX = W'(N);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_IDLE  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_up, r_dn, r_lt, r_rt, r_wr;
  logic [AW-1:0]  r_row, r_col, w_row_nxt, w_col_nxt;
  logic [RW-1:0]  r_buf, w_buf_nxt;
  logic [RW-1:0]  r_wbuf, w_wbuf_nxt;
  logic           r_we, w_we_nxt;
  logic           r_nowr, w_nowr_nxt;
  logic           r_bad, w_bad_nxt;
  logic           w_nav;

  logic [W-1:0]   w_cells [N];
  logic [N-1:0]   w_prot_bits;
  logic [W-1:0]   w_cell;
  logic           w_prot;

  generate
    for (genvar c = 0; c < N; c++) begin : g_cells
      assign w_cells[c] = r_buf[c*W +: W];
    end
  endgenerate

  assign w_prot_bits = r_buf[RW-1 -: N];
  assign w_cell      = w_cells[r_col];
  assign w_prot      = w_prot_bits[r_col];

  // Rising-edge events: raw input against its previous registered sample.
  logic w_up_ev, w_dn_ev, w_lt_ev, w_rt_ev, w_wr_ev;
  assign w_up_ev = upButton    & ~r_up;
  assign w_dn_ev = downButton  & ~r_dn;
  assign w_lt_ev = leftButton  & ~r_lt;
  assign w_rt_ev = rightButton & ~r_rt;
  assign w_wr_ev = (WMODE != 0) ? (writeBit && (userNum != w_cell))
                                : (writeBit & ~r_wr);

  logic [AW-1:0] w_row_up, w_row_dn, w_col_lt, w_col_rt;
  assign w_row_up = (r_row == '0)     ? ((WRAP != 0) ? c_LAST : '0)     : r_row - AW'(1);
  assign w_row_dn = (r_row == c_LAST) ? ((WRAP != 0) ? '0     : c_LAST) : r_row + AW'(1);
  assign w_col_lt = (r_col == '0)     ? ((WRAP != 0) ? c_LAST : '0)     : r_col - AW'(1);
  assign w_col_rt = (r_col == c_LAST) ? ((WRAP != 0) ? '0     : c_LAST) : r_col + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_buf_nxt   = r_buf;
    w_wbuf_nxt  = r_wbuf;
    w_we_nxt    = 1'b0;
    w_nowr_nxt  = r_nowr;
    w_bad_nxt   = r_bad;
    w_nav       = 1'b0;

    case (r_state)
      S_INIT:  w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_buf_nxt   = RamDat;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_up_ev) begin
          w_nav     = 1'b1;
          w_row_nxt = w_row_up;
          if (w_row_up != r_row) w_state_nxt = S_FETCH;
        end else if (w_dn_ev) begin
          w_nav     = 1'b1;
          w_row_nxt = w_row_dn;
          if (w_row_dn != r_row) w_state_nxt = S_FETCH;
        end else if (w_lt_ev) begin
          w_nav     = 1'b1;
          w_col_nxt = w_col_lt;
        end else if (w_rt_ev) begin
          w_nav     = 1'b1;
          w_col_nxt = w_col_rt;
        end else if (w_wr_ev) begin
          if (w_prot) begin
            w_nowr_nxt = 1'b1;
          end else if (userNum > c_NMAX) begin
            w_bad_nxt = 1'b1;
          end else begin
            for (int c = 0; c < N; c++) begin
              if (AW'(c) == r_col) w_buf_nxt[c*W +: W] = userNum;
            end
            w_wbuf_nxt  = w_buf_nxt;
            w_we_nxt    = 1'b1;
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase

    // Error flags persist until the user moves or releases the write switch.
    if (w_nav || !writeBit) begin
      w_nowr_nxt = 1'b0;
      w_bad_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_INIT;
      r_row   <= '0;
      r_col   <= '0;
      r_buf   <= '0;
      r_wbuf  <= '0;
      r_we    <= 1'b0;
      r_nowr  <= 1'b0;
      r_bad   <= 1'b0;
      r_up    <= 1'b0;
      r_dn    <= 1'b0;
      r_lt    <= 1'b0;
      r_rt    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_buf   <= w_buf_nxt;
      r_wbuf  <= w_wbuf_nxt;
      r_we    <= w_we_nxt;
      r_nowr  <= w_nowr_nxt;
      r_bad   <= w_bad_nxt;
      r_up    <= upButton;
      r_dn    <= downButton;
      r_lt    <= leftButton;
      r_rt    <= rightButton;
      r_wr    <= writeBit;
    end
  end

  assign RamAddr     = r_row;
  assign RamWriteBuf = r_wbuf;
  assign RamWriteBit = r_we;
  assign currentRow  = r_buf[N*W-1:0];
  assign currentNum  = w_cell;
  assign curRow      = r_row;
  assign curCol      = r_col;
  assign noWrite     = r_nowr;
  assign badNum      = r_bad;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sudoku_grid_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sudoku_grid_ctrl : directed stimulus for three board configurations
// Revision 1.0
// ============================================================================

module tb_sudoku_grid_ctrl;

  localparam int NA = 4;
  localparam int WA = 4;
  localparam int RWA = NA * (WA + 1);
  localparam int NC = 9;
  localparam int RWC = NC * 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT A : N=4, wrap, edge-commit ----------------
  logic [3:0]     a_num;
  logic           a_up, a_dn, a_lt, a_rt, a_wr;
  logic [RWA-1:0] a_rdat, a_wbuf;
  logic [1:0]     a_addr, a_crow, a_ccol;
  logic           a_we, a_now, a_bad, a_busy;
  logic [15:0]    a_row;
  logic [3:0]     a_cnum;
  logic [RWA-1:0] mem_a [4] = '{20'h0_1234, 20'h9_5678, 20'h0_ABCD, 20'hF_4321};

  sudoku_grid_ctrl #(.N(4), .W(4), .WRAP(1), .WMODE(0)) u_a (
    .CLK(clk), .RST(rst), .userNum(a_num),
    .upButton(a_up), .downButton(a_dn), .leftButton(a_lt), .rightButton(a_rt),
    .writeBit(a_wr), .RamDat(a_rdat), .RamAddr(a_addr), .RamWriteBuf(a_wbuf),
    .RamWriteBit(a_we), .currentRow(a_row), .currentNum(a_cnum),
    .curRow(a_crow), .curCol(a_ccol), .noWrite(a_now), .badNum(a_bad), .busy(a_busy)
  );

  always @(posedge clk) begin
    a_rdat <= mem_a[a_addr];
    if (a_we) mem_a[a_addr] <= a_wbuf;
  end

  // ---------------- DUT B : N=4, saturating cursor ----------------
  logic [3:0]     b_num;
  logic           b_up, b_dn, b_lt, b_rt, b_wr;
  logic [RWA-1:0] b_rdat, b_wbuf;
  logic [1:0]     b_addr, b_crow, b_ccol;
  logic           b_we, b_now, b_bad, b_busy;
  logic [15:0]    b_row;
  logic [3:0]     b_cnum;
  logic [RWA-1:0] mem_b [4] = '{default: '0};

  sudoku_grid_ctrl #(.N(4), .W(4), .WRAP(0), .WMODE(0)) u_b (
    .CLK(clk), .RST(rst), .userNum(b_num),
    .upButton(b_up), .downButton(b_dn), .leftButton(b_lt), .rightButton(b_rt),
    .writeBit(b_wr), .RamDat(b_rdat), .RamAddr(b_addr), .RamWriteBuf(b_wbuf),
    .RamWriteBit(b_we), .currentRow(b_row), .currentNum(b_cnum),
    .curRow(b_crow), .curCol(b_ccol), .noWrite(b_now), .badNum(b_bad), .busy(b_busy)
  );

  always @(posedge clk) begin
    b_rdat <= mem_b[b_addr];
    if (b_we) mem_b[b_addr] <= b_wbuf;
  end

  // ---------------- DUT C : N=9, level-commit ----------------
  logic [3:0]     c_num;
  logic           c_up, c_dn, c_lt, c_rt, c_wr;
  logic [RWC-1:0] c_rdat, c_wbuf;
  logic [3:0]     c_addr, c_crow, c_ccol;
  logic           c_we, c_now, c_bad, c_busy;
  logic [35:0]    c_row;
  logic [3:0]     c_cnum;
  logic [RWC-1:0] mem_c [16] = '{default: '0};
  int             c_pulses = 0;

  sudoku_grid_ctrl #(.N(9), .W(4), .WRAP(1), .WMODE(1)) u_c (
    .CLK(clk), .RST(rst), .userNum(c_num),
    .upButton(c_up), .downButton(c_dn), .leftButton(c_lt), .rightButton(c_rt),
    .writeBit(c_wr), .RamDat(c_rdat), .RamAddr(c_addr), .RamWriteBuf(c_wbuf),
    .RamWriteBit(c_we), .currentRow(c_row), .currentNum(c_cnum),
    .curRow(c_crow), .curCol(c_ccol), .noWrite(c_now), .badNum(c_bad), .busy(c_busy)
  );

  always @(posedge clk) begin
    c_rdat <= mem_c[c_addr];
    if (c_we) mem_c[c_addr] <= c_wbuf;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- Behavioural model of DUT A ----------------
  // Busy time is a countdown of remaining non-interactive cycles; the board
  // itself is an array of rows updated whenever a commit is predicted.
  bit             m_on = 1'b0;
  int             m_busy, m_row, m_col;
  bit             m_latch, m_we, m_now, m_bad;
  bit             p_up, p_dn, p_lt, p_rt, p_wr;
  logic [RWA-1:0] m_view, m_wbuf;
  logic [RWA-1:0] m_mem [4] = '{20'h0_1234, 20'h9_5678, 20'h0_ABCD, 20'hF_4321};

  task automatic model_step();
    bit eu, ed, el, er, ew, nav;
    int sh, nr;
    if (rst) begin
      m_on = 1'b1; m_busy = 3; m_latch = 1'b1; m_row = 0; m_col = 0;
      m_view = '0; m_we = 1'b0; m_now = 1'b0; m_bad = 1'b0;
      {p_up, p_dn, p_lt, p_rt, p_wr} = '0;
      return;
    end
    eu = a_up & ~p_up; ed = a_dn & ~p_dn; el = a_lt & ~p_lt;
    er = a_rt & ~p_rt; ew = a_wr & ~p_wr;
    {p_up, p_dn, p_lt, p_rt, p_wr} = {a_up, a_dn, a_lt, a_rt, a_wr};
    m_we = 1'b0;
    nav  = 1'b0;
    sh   = m_col * WA;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_latch) m_view = m_mem[m_row];
    end else if (eu || ed) begin
      nav = 1'b1;
      nr  = eu ? (m_row + NA - 1) % NA : (m_row + 1) % NA;
      if (nr != m_row) begin m_row = nr; m_busy = 2; m_latch = 1'b1; end
    end else if (el) begin
      nav = 1'b1; m_col = (m_col + NA - 1) % NA;
    end else if (er) begin
      nav = 1'b1; m_col = (m_col + 1) % NA;
    end else if (ew) begin
      if (((m_view >> (NA * WA + m_col)) & 1) != 0) m_now = 1'b1;
      else if (int'(a_num) > NA) m_bad = 1'b1;
      else begin
        m_view = (m_view & ~(RWA'(4'hF) << sh)) | (RWA'(a_num) << sh);
        m_mem[m_row] = m_view;
        m_wbuf = m_view;
        m_we = 1'b1; m_busy = 1; m_latch = 1'b0;
      end
    end
    if (nav || !a_wr) begin m_now = 1'b0; m_bad = 1'b0; end
  endtask

  task automatic model_check();
    if (!m_on) return;
    check("m_busy",    a_busy, (m_busy != 0));
    check("m_curRow",  a_crow, m_row);
    check("m_curCol",  a_ccol, m_col);
    check("m_RamAddr", a_addr, m_row);
    check("m_curRowData", a_row, m_view[15:0]);
    check("m_curNum",  a_cnum, (m_view >> (m_col * WA)) & 20'hF);
    check("m_noWrite", a_now, m_now);
    check("m_badNum",  a_bad, m_bad);
    check("m_wrPulse", a_we, m_we);
    if (m_we) check("m_wrBuf", a_wbuf, m_wbuf);
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
    end
  end

  // ---------------- Directed stimulus with literal expectations ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_c(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (c_we) c_pulses++;
    end
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    {a_up, a_dn, a_lt, a_rt, a_wr} = '0; a_num = '0;
    {b_up, b_dn, b_lt, b_rt, b_wr} = '0; b_num = '0;
    {c_up, c_dn, c_lt, c_rt, c_wr} = '0; c_num = '0;

    tick();
    check("rst_busy", a_busy, 1);
    check("rst_we", a_we, 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (a_busy && n < 10) begin n++; tick(); end
    check("boot_busy_cycles", n, 3);
    check("boot_row", a_row, 16'h1234);
    check("boot_num", a_cnum, 4);
    check("boot_pos", {a_crow, a_ccol}, 0);

    // Up at row 0 wraps to 3; new data appears two edges after the event.
    a_up = 1'b1; tick();
    check("up_wrap_row", a_crow, 3);
    check("up_wrap_addr", a_addr, 3);
    check("up_busy", a_busy, 1);
    tick();
    check("lat_old_row", a_row, 16'h1234);
    tick();
    check("lat_new_row", a_row, 16'h4321);
    check("lat_idle", a_busy, 0);
    a_up = 1'b0; tick();

    repeat (2) begin a_dn = 1'b1; tick(); a_dn = 1'b0; tick(3); end
    check("dn_row", a_crow, 1);
    check("dn_data", a_row, 16'h5678);

    repeat (2) begin a_rt = 1'b1; tick(); a_rt = 1'b0; tick(); end
    check("rt_col", a_ccol, 2);
    check("rt_num", a_cnum, 6);

    // Valid write at (1,2).
    a_num = 4'd3; a_wr = 1'b1; tick();
    check("wr_pulse", a_we, 1);
    check("wr_addr", a_addr, 1);
    check("wr_buf", a_wbuf, 20'h9_5378);
    tick();
    check("wr_pulse_end", a_we, 0);
    check("wr_cell", a_cnum, 3);
    a_wr = 1'b0; tick();
    check("wr_mem", mem_a[1], 20'h9_5378);

    // Protected cell (1,3).
    a_rt = 1'b1; tick(); a_rt = 1'b0; tick();
    a_wr = 1'b1; tick();
    check("prot_nowrite", a_now, 1);
    check("prot_we", a_we, 0);
    tick();
    check("prot_hold", a_now, 1);
    a_wr = 1'b0; tick();
    check("prot_clear", a_now, 0);

    // Out-of-range value at (1,2).
    a_lt = 1'b1; tick(); a_lt = 1'b0; tick();
    a_num = 4'd7; a_wr = 1'b1; tick();
    check("bad_flag", a_bad, 1);
    check("bad_we", a_we, 0);
    a_wr = 1'b0; tick();
    check("bad_clear", a_bad, 0);
    check("bad_mem", mem_a[1], 20'h9_5378);

    // Up and right together: only the row moves.
    a_up = 1'b1; a_rt = 1'b1; tick();
    check("ur_row", a_crow, 0);
    check("ur_col", a_ccol, 2);
    a_up = 1'b0; a_rt = 1'b0; tick(3);

    // Right pressed while fetching is dropped.
    a_dn = 1'b1; tick();
    a_rt = 1'b1; tick(3);
    check("fetch_ign_col", a_ccol, 2);
    check("fetch_row", a_crow, 1);
    a_dn = 1'b0; a_rt = 1'b0; tick();

    // Saturating cursor.
    b_up = 1'b1; tick();
    check("sat_up_row", b_crow, 0);
    check("sat_up_busy", b_busy, 0);
    b_up = 1'b0; b_lt = 1'b1; tick();
    check("sat_lt_col", b_ccol, 0);
    b_lt = 1'b0; tick();
    repeat (3) begin b_dn = 1'b1; tick(); b_dn = 1'b0; tick(3); end
    b_dn = 1'b1; tick();
    check("sat_dn_row", b_crow, 3);
    check("sat_dn_busy", b_busy, 0);
    b_dn = 1'b0; tick();

    // Level-commit mode on a 9x9 board.
    c_dn = 1'b1; tick_c(); c_dn = 1'b0; tick_c(3);
    c_rt = 1'b1; tick_c(); c_rt = 1'b0; tick_c();
    check("c_pos", {c_crow, c_ccol}, 8'h11);
    c_wr = 1'b1; c_num = 4'd5; tick_c(4);
    check("c_pulses_5", c_pulses, 1);
    c_num = 4'd6; tick_c(4);
    check("c_pulses_6", c_pulses, 2);
    c_num = 4'd9; tick_c(4);
    check("c_pulses_9", c_pulses, 3);
    check("c_num9", c_cnum, 9);
    check("c_mem_cell", mem_c[1][7:4], 9);
    c_num = 4'd3; tick_c();
    check("c_wr_pre_rst", c_we, 1);
    rst = 1'b1; c_wr = 1'b0; tick_c();
    check("c_rst_we", c_we, 0);
    check("c_rst_busy", c_busy, 1);
    rst = 1'b0; tick_c(6);
    check("c_pulses_final", c_pulses, 4);
    check("c_rst_pos", {c_crow, c_ccol}, 0);
    check("c_rst_idle", c_busy, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
